// File: rtl/conv_ddr_rd_arbiter.sv
// conv_ddr_rd_arbiter
//   Shares the single conv DDR read port between two burst requesters
//   (0: ifmap loader, 1: weight loader). Round-robin on ties; the granted
//   burst issues one read beat per cycle, counts returned beats and steers
//   the returned data to its owner through per-requester valid strobes.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   req0/req1               level requests, held until the matching done
//   reqN_adr, reqN_len      burst base byte address / beat count, sampled at grant
//   gnt0/gnt1               high for the whole granted transfer
//   done0/done1             one-cycle pulse once the burst has fully returned
//   rd_valid0/rd_valid1     rd_data beat belongs to requester N
//   rd_data                 registered copy of ddr_data
//   busy                    arbiter not idle
//   ddr_rd, ddr_rd_adr      DDR read strobe and beat address
//   ddr_data, valid_ddr_data DDR return data and its valid
//
// state | meaning
// IDLE  | no transfer; arbitrate between pending requests
// ISSUE | granted burst issuing one ddr_rd beat per cycle
// DRAIN | all beats issued, waiting for the remaining returns
// DONE  | done pulse visible, grant drops at the end of this cycle
module conv_ddr_rd_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 512,
  parameter int LEN_W      = 16,
  parameter int BEAT_BYTES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] req0_adr,
  input  logic [LEN_W-1:0]  req0_len,
  input  logic              req1,
  input  logic [ADDR_W-1:0] req1_adr,
  input  logic [LEN_W-1:0]  req1_len,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              rd_valid0,
  output logic              rd_valid1,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              ddr_rd,
  output logic [ADDR_W-1:0] ddr_rd_adr,
  input  logic [DATA_W-1:0] ddr_data,
  input  logic              valid_ddr_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state;
  logic              owner;
  logic              rr_ptr;
  logic [ADDR_W-1:0] nxt_adr;
  logic [LEN_W-1:0]  issue_left;
  logic [LEN_W-1:0]  rcv_left;

  logic              pick;
  logic [ADDR_W-1:0] pick_adr;
  logic [LEN_W-1:0]  pick_len;
  logic              beat_take;
  logic              rcv_last;

  always_comb begin
    pick      = (req0 & req1) ? rr_ptr : req1;
    pick_adr  = pick ? req1_adr : req0_adr;
    pick_len  = pick ? req1_len : req0_len;
    // Beats outside a transfer, or beyond the burst length, are dropped.
    beat_take = valid_ddr_data && ((state == ISSUE) || (state == DRAIN)) &&
                (rcv_left != '0);
    rcv_last  = beat_take && (rcv_left == LEN_W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      rr_ptr     <= 1'b0;
      nxt_adr    <= '0;
      issue_left <= '0;
      rcv_left   <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      rd_valid0  <= 1'b0;
      rd_valid1  <= 1'b0;
      rd_data    <= '0;
      busy       <= 1'b0;
      ddr_rd     <= 1'b0;
      ddr_rd_adr <= '0;
    end else begin
      ddr_rd    <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      rd_valid0 <= 1'b0;
      rd_valid1 <= 1'b0;

      if (beat_take) begin
        rd_data   <= ddr_data;
        rd_valid0 <= ~owner;
        rd_valid1 <= owner;
        rcv_left  <= rcv_left - LEN_W'(1);
      end

      case (state)
        IDLE: begin
          if (req0 | req1) begin
            owner      <= pick;
            gnt0       <= ~pick;
            gnt1       <= pick;
            nxt_adr    <= pick_adr;
            issue_left <= pick_len;
            rcv_left   <= pick_len;
            busy       <= 1'b1;
            // A zero-length burst passes through DRAIN, which completes at
            // once, so its grant is still visible for two cycles.
            state      <= (pick_len != '0) ? ISSUE : DRAIN;
          end
        end

        ISSUE: begin
          if (rcv_last) begin
            done0 <= ~owner;
            done1 <= owner;
            state <= DONE;
          end else begin
            ddr_rd     <= 1'b1;
            ddr_rd_adr <= nxt_adr;
            nxt_adr    <= nxt_adr + ADDR_W'(BEAT_BYTES);
            issue_left <= issue_left - LEN_W'(1);
            if (issue_left == LEN_W'(1)) state <= DRAIN;
          end
        end

        DRAIN: begin
          if (rcv_last || (rcv_left == '0)) begin
            done0 <= ~owner;
            done1 <= owner;
            state <= DONE;
          end
        end

        DONE: begin
          gnt0   <= 1'b0;
          gnt1   <= 1'b0;
          busy   <= 1'b0;
          rr_ptr <= ~owner;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_ddr_rd_arbiter.sv
// Directed bench for conv_ddr_rd_arbiter with a configurable-latency DDR model.
module tb_conv_ddr_rd_arbiter;
  localparam int AW = 32;
  localparam int DW = 512;
  localparam int LW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          req0, req1;
  logic [AW-1:0] req0_adr, req1_adr;
  logic [LW-1:0] req0_len, req1_len;
  logic          gnt0, gnt1, done0, done1, rd_valid0, rd_valid1, busy, ddr_rd;
  logic [DW-1:0] rd_data, ddr_data;
  logic [AW-1:0] ddr_rd_adr;
  logic          valid_ddr_data;

  conv_ddr_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .BEAT_BYTES(64)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req0_adr(req0_adr), .req0_len(req0_len),
    .req1(req1), .req1_adr(req1_adr), .req1_len(req1_len),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rd_valid0(rd_valid0), .rd_valid1(rd_valid1), .rd_data(rd_data),
    .busy(busy), .ddr_rd(ddr_rd), .ddr_rd_adr(ddr_rd_adr),
    .ddr_data(ddr_data), .valid_ddr_data(valid_ddr_data)
  );

  int tests = 0;
  int fails = 0;

  // DDR model: each issued beat returns 'lat' cycles later carrying its
  // own address replicated across the data word; inj_v forces stray beats.
  int          lat;
  logic        inj_v;
  logic [31:0] inj_a;
  logic [31:0] dv;
  logic [31:0] da [32];

  always @(posedge clk) begin
    dv    <= {dv[30:0], ddr_rd};
    da[0] <= ddr_rd_adr;
    for (int i = 1; i < 32; i++) da[i] <= da[i-1];
  end

  assign valid_ddr_data = dv[lat-1] | inj_v;
  assign ddr_data       = dv[lat-1] ? {16{da[lat-1]}} : {16{inj_a}};

  // Monitor
  logic        mon_clr;
  int          cyc = 0;
  int          v0, v1, d0, d1, g0c, g1c, v0_at_done;
  int          gnt_rise_cyc, first_rd_cyc;
  logic [31:0] adr_q[$];
  int          order_q[$];
  logic [DW-1:0] last_d0, last_d1;
  logic        prev_g0, prev_g1;

  always @(negedge clk) begin
    cyc++;
    if (mon_clr) begin
      adr_q.delete(); order_q.delete();
      v0 = 0; v1 = 0; d0 = 0; d1 = 0; g0c = 0; g1c = 0; v0_at_done = -1;
      gnt_rise_cyc = 0; first_rd_cyc = 0;
    end else begin
      if (ddr_rd) begin
        if (adr_q.size() == 0) first_rd_cyc = cyc;
        adr_q.push_back(ddr_rd_adr);
      end
      if (rd_valid0) begin v0++; last_d0 = rd_data; end
      if (rd_valid1) begin v1++; last_d1 = rd_data; end
      if (done0) begin d0++; v0_at_done = v0; end
      if (done1) d1++;
      if (gnt0) g0c++;
      if (gnt1) g1c++;
      if (gnt0 && !prev_g0) begin
        if (order_q.size() == 0) gnt_rise_cyc = cyc;
        order_q.push_back(0);
      end
      if (gnt1 && !prev_g1) begin
        if (order_q.size() == 0) gnt_rise_cyc = cyc;
        order_q.push_back(1);
      end
    end
    prev_g0 = gnt0;
    prev_g1 = gnt1;
  end

  task automatic clear_mon();
    mon_clr = 1'b1;
    repeat (2) @(negedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done0 | done1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_burst(input bit sel, input logic [31:0] adr, input logic [15:0] len,
                          output bit ok);
    if (!sel) begin req0_adr = adr; req0_len = len; req0 = 1'b1; end
    else      begin req1_adr = adr; req1_len = len; req1 = 1'b1; end
    wait_done(200, ok);
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Both requesters re-request immediately after each of their bursts.
  task automatic run_pair(input int quota, output bit ok);
    int n0, n1;
    n0 = 0; n1 = 0; ok = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done0) begin req0 = 1'b0; n0++; end
      else if (!req0 && n0 < quota) req0 = 1'b1;
      if (done1) begin req1 = 1'b0; n1++; end
      else if (!req1 && n1 < quota) req1 = 1'b1;
      if (n0 >= quota && n1 >= quota) begin ok = 1'b1; break; end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (12) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (12) @(negedge clk);
    tests++;
    if ({gnt0, gnt1, done0, done1, rd_valid0, rd_valid1, busy, ddr_rd} !== 8'h00) begin
      fails++; $display("FAIL reset_flags: got %b, expected 00000000",
                        {gnt0, gnt1, done0, done1, rd_valid0, rd_valid1, busy, ddr_rd});
    end
    tests++;
    if (ddr_rd_adr !== 32'h0 || rd_data !== '0) begin
      fails++; $display("FAIL reset_data: adr %h, expected 0", ddr_rd_adr);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      fails++; $display("FAIL idle_after_reset: busy %b gnt %b%b, expected 0", busy, gnt0, gnt1);
    end
  endtask

  task automatic test_single();
    bit ok;
    logic [31:0] exp_a [4];
    exp_a[0] = 32'h1000; exp_a[1] = 32'h1040; exp_a[2] = 32'h1080; exp_a[3] = 32'h10C0;
    lat = 1;
    clear_mon();
    do_burst(1'b0, 32'h1000, 16'd4, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL single_timeout: got no done, expected done0"); end
    tests++;
    if (adr_q.size() != 4) begin
      fails++; $display("FAIL single_rd_count: got %0d, expected 4", adr_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (adr_q[i] !== exp_a[i]) begin
          fails++; $display("FAIL single_adr%0d: got %h, expected %h", i, adr_q[i], exp_a[i]);
        end
      end
    end
    tests++;
    if (v0 != 4 || v1 != 0) begin
      fails++; $display("FAIL single_valid: got v0=%0d v1=%0d, expected 4/0", v0, v1);
    end
    tests++;
    if (d0 != 1 || d1 != 0) begin
      fails++; $display("FAIL single_done: got d0=%0d d1=%0d, expected 1/0", d0, d1);
    end
    tests++;
    if (last_d0 !== {16{32'h10C0}}) begin
      fails++; $display("FAIL single_data: got %h, expected replicated 10c0", last_d0[31:0]);
    end
    tests++;
    if (first_rd_cyc - gnt_rise_cyc != 1) begin
      fails++; $display("FAIL single_first_rd: got %0d cycles after grant, expected 1",
                        first_rd_cyc - gnt_rise_cyc);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    apply_reset();
    lat = 2;
    req0_adr = 32'h4000; req0_len = 16'd2;
    req1_adr = 32'h8000; req1_len = 16'd2;
    clear_mon();
    run_pair(4, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL rr_timeout: got incomplete, expected 4+4 bursts"); end
    tests++;
    if (order_q.size() != 8) begin
      fails++; $display("FAIL rr_grants: got %0d, expected 8", order_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests++;
        if (order_q[i] != (i % 2)) begin
          fails++; $display("FAIL rr_order%0d: got %0d, expected %0d", i, order_q[i], i % 2);
        end
      end
    end
    tests++;
    if (v0 != 8 || v1 != 8 || d0 != 4 || d1 != 4) begin
      fails++; $display("FAIL rr_counts: got v=%0d/%0d d=%0d/%0d, expected 8/8 4/4", v0, v1, d0, d1);
    end
  endtask

  task automatic test_zero_len();
    bit ok;
    lat = 1;
    do_burst(1'b0, 32'h0100, 16'd1, ok);
    clear_mon();
    do_burst(1'b1, 32'h0200, 16'd0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL zero_timeout: got no done, expected done1"); end
    tests++;
    if (g1c != 2) begin fails++; $display("FAIL zero_gnt_cycles: got %0d, expected 2", g1c); end
    tests++;
    if (adr_q.size() != 0) begin
      fails++; $display("FAIL zero_ddr_rd: got %0d beats, expected 0", adr_q.size());
    end
    tests++;
    if (d1 != 1 || v1 != 0) begin
      fails++; $display("FAIL zero_done: got d1=%0d v1=%0d, expected 1/0", d1, v1);
    end
    req0_len = 16'd0; req1_len = 16'd0;
    clear_mon();
    run_pair(1, ok);
    tests++;
    if (!ok || order_q.size() == 0 || order_q[0] != 0) begin
      fails++; $display("FAIL zero_rr_flip: got first grant %0d, expected 0",
                        (order_q.size() == 0) ? -1 : order_q[0]);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [31:0] exp_a [3];
    exp_a[0] = 32'hFFFF_FFC0; exp_a[1] = 32'h0000_0000; exp_a[2] = 32'h0000_0040;
    lat = 1;
    clear_mon();
    do_burst(1'b1, 32'hFFFF_FFC0, 16'd3, ok);
    tests++;
    if (!ok || adr_q.size() != 3) begin
      fails++; $display("FAIL wrap_beats: got %0d, expected 3", adr_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (adr_q[i] !== exp_a[i]) begin
          fails++; $display("FAIL wrap_adr%0d: got %h, expected %h", i, adr_q[i], exp_a[i]);
        end
      end
    end
    tests++;
    if (v1 != 3 || d1 != 1 || last_d1 !== {16{32'h40}}) begin
      fails++; $display("FAIL wrap_return: got v1=%0d d1=%0d, expected 3/1", v1, d1);
    end
  endtask

  task automatic test_late_data();
    bit ok;
    lat = 10;
    clear_mon();
    req0_adr = 32'h3000; req0_len = 16'd3; req0 = 1'b1;
    wait_done(100, ok);
    req0 = 1'b0;
    tests++;
    if (!ok) begin fails++; $display("FAIL late_timeout: got no done, expected done0"); end
    inj_a = 32'hDEAD_0000;
    inj_v = 1'b1;
    repeat (2) @(negedge clk);
    inj_v = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (v0_at_done != 3) begin
      fails++; $display("FAIL late_done_point: got %0d beats at done, expected 3", v0_at_done);
    end
    tests++;
    if (v0 != 3 || v1 != 0 || d0 != 1) begin
      fails++; $display("FAIL late_spurious: got v0=%0d v1=%0d d0=%0d, expected 3/0/1", v0, v1, d0);
    end
    lat = 1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n_iss;
    lat = 1;
    clear_mon();
    req0_adr = 32'h5000; req0_len = 16'd8; req0 = 1'b1;
    n_iss = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ddr_rd) n_iss++;
      if (n_iss == 2) break;
    end
    tests++;
    if (n_iss != 2) begin fails++; $display("FAIL mid_issue: got %0d beats, expected 2", n_iss); end
    reset = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    tests++;
    if ({gnt0, gnt1, done0, done1, rd_valid0, rd_valid1, busy, ddr_rd} !== 8'h00 ||
        ddr_rd_adr !== 32'h0) begin
      fails++; $display("FAIL mid_reset_out: got %b adr %h, expected 0",
                        {gnt0, gnt1, done0, done1, rd_valid0, rd_valid1, busy, ddr_rd}, ddr_rd_adr);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (d0 != 0) begin fails++; $display("FAIL mid_no_done: got d0=%0d, expected 0", d0); end
    clear_mon();
    do_burst(1'b1, 32'h2000, 16'd2, ok);
    tests++;
    if (!ok || adr_q.size() != 2 || adr_q[0] !== 32'h2000 || adr_q[1] !== 32'h2040) begin
      fails++; $display("FAIL mid_new_burst: got %0d beats, expected 2 at 2000/2040", adr_q.size());
    end
    tests++;
    if (v1 != 2 || d1 != 1 || v0 != 0) begin
      fails++; $display("FAIL mid_new_return: got v1=%0d d1=%0d v0=%0d, expected 2/1/0", v1, d1, v0);
    end
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    req0_adr = '0; req1_adr = '0; req0_len = '0; req1_len = '0;
    lat = 1; inj_v = 1'b0; inj_a = '0;
    mon_clr = 1'b1;
    test_reset();
    mon_clr = 1'b0;
    test_single();
    test_round_robin();
    test_zero_len();
    test_wrap();
    test_late_data();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
